// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: sequences a dynamically reconfigurable PLL through gate, reset, lock filter and retry.
module pll_reconfig_seq #(
  parameter int NUM_OUT     = 1,
  parameter int DEF_IDIV    = 1,
  parameter int DEF_FBDIV   = 1,
  parameter int DEF_MDIV    = 10,
  parameter int DEF_ODIV    = 8,
  parameter int RST_CYC     = 16,
  parameter int FILT_CYC    = 1024,
  parameter int TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [5:0]             cfg_idiv_i,
  input  logic [5:0]             cfg_fbdiv_i,
  input  logic [6:0]             cfg_mdiv_i,
  input  logic [7*NUM_OUT-1:0]   cfg_odiv_i,
  input  logic                   pll_lock_i,
  output logic                   pll_reset_o,
  output logic [5:0]             pll_idsel_o,
  output logic [5:0]             pll_fbdsel_o,
  output logic [6:0]             pll_mdsel_o,
  output logic [7*NUM_OUT-1:0]   pll_odsel_o,
  output logic [NUM_OUT-1:0]     pll_enclk_o,
  output logic                   locked_o,
  output logic                   err_o,
  output logic [1:0]             retry_cnt_o
);
  localparam int TMAX = TIMEOUT_CYC > RST_CYC ? TIMEOUT_CYC : RST_CYC;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int FW = $clog2(FILT_CYC) + 1;
  localparam int CW = 19 + 7 * NUM_OUT;
  localparam logic [CW-1:0] DEF_CFG = {6'(DEF_IDIV), 6'(DEF_FBDIV), 7'(DEF_MDIV), {NUM_OUT{7'(DEF_ODIV)}}};
  typedef enum logic [2:0] {GATE, RST, WAIT, FILT, LOCKED, FAIL} state_t;
  state_t state_q, state_d, retry_st;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [1:0] retry_q, retry_d, lk_q;
  logic [CW-1:0] cfg_q, div_q;
  logic [2:0] rinc;
  logic lk_s, accept, tmo;
  assign lk_s = lk_q[1];
  assign accept = cfg_valid_i & cfg_ready_o;
  assign tmo = tmr_q == TW'(TIMEOUT_CYC - 1);
  assign rinc = {1'b0, retry_q} + 3'd1;
  assign retry_st = int'(rinc) < MAX_RETRY ? RST : FAIL;
  assign retry_cnt_o = retry_q;
  assign {pll_idsel_o, pll_fbdsel_o, pll_mdsel_o, pll_odsel_o} = div_q;
  // The timeout timer keeps running across FILT->WAIT bounces; only RST exit clears it.
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q + TW'(1);
    filt_d = '0;
    retry_d = retry_q;
    case (state_q)
      GATE: if (tmr_q == TW'(1)) begin
        state_d = RST;
        tmr_d = '0;
      end
      RST: if (tmr_q == TW'(RST_CYC - 1)) begin
        state_d = WAIT;
        tmr_d = '0;
      end
      WAIT, FILT: begin
        filt_d = (state_q == FILT && lk_s) ? filt_q + FW'(1) : '0;
        if (state_q == FILT && lk_s && filt_q == FW'(FILT_CYC - 1)) state_d = LOCKED;
        else if (tmo) begin
          state_d = retry_st;
          retry_d = rinc[2] ? 2'd3 : rinc[1:0];
          tmr_d = '0;
        end else state_d = lk_s ? FILT : WAIT;
      end
      LOCKED: begin
        tmr_d = '0;
        if (!lk_s) begin
          state_d = RST;
          retry_d = '0;
        end
      end
      FAIL: tmr_d = '0;
      default: state_d = RST;
    endcase
    if (accept) begin
      state_d = GATE;
      tmr_d = '0;
      retry_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST;
      tmr_q <= '0;
      filt_q <= '0;
      retry_q <= '0;
      lk_q <= '0;
      cfg_q <= DEF_CFG;
      div_q <= DEF_CFG;
      pll_reset_o <= 1'b1;
      pll_enclk_o <= '0;
      locked_o <= 1'b0;
      err_o <= 1'b0;
      cfg_ready_o <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      filt_q <= filt_d;
      retry_q <= retry_d;
      lk_q <= {lk_q[0], pll_lock_i};
      if (accept) cfg_q <= {cfg_idiv_i, cfg_fbdiv_i, cfg_mdiv_i, cfg_odiv_i};
      if (state_d == RST && state_q != RST) div_q <= cfg_q;
      pll_reset_o <= state_d == RST || state_d == FAIL;
      pll_enclk_o <= {NUM_OUT{state_d == LOCKED}};
      locked_o <= state_d == LOCKED;
      err_o <= state_d == FAIL;
      cfg_ready_o <= state_d == LOCKED || state_d == FAIL;
    end
  end
endmodule
